hps_rs_control_bridge: RTL and testbench

HPS_RS_CONTROL_BRIDGE -- requirements
Module: hps_rs_control_bridge

---
 rtl/hps_rs_bridge_pkg.sv | 22 ++
 rtl/hps_rs_control_bridge.sv | 135 +++++++++++++
 tb/tb_hps_rs_control_bridge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_rs_bridge_pkg.sv
// Shared types and constants for the HPS-to-RS control bridge: command codes,
// bridge FSM states and the memory-wait timeout used by HPS_RS_BRIDGE_TIMEOUT_EN builds.
package hps_rs_bridge_pkg;

  typedef enum logic [2:0] {
    CMD_MEM = 3'b000,
    CMD_DEC = 3'b010,
    CMD_ENC = 3'b011
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          TIMEOUT_CYCLES = 256;
  localparam int          TIMEOUT_CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF;

endpackage

// File: rtl/hps_rs_control_bridge.sv
// Avalon-MM slave that forwards word accesses to the HPS memory port and issues
// Reed-Solomon encode/decode start commands. Define HPS_RS_BRIDGE_TIMEOUT_EN to bound memory waits.
module hps_rs_control_bridge
  import hps_rs_bridge_pkg::*;
#(
  parameter int SLAVE_ADDR_BITWIDTH = 32
) (
  input  logic                           aclk_i,
  input  logic                           aresetn_i,
  input  logic                           chipselect_i,
  input  logic                           read_i,
  input  logic                           write_i,
  input  logic [SLAVE_ADDR_BITWIDTH-1:0] address_i,
  input  logic [31:0]                    writedata_i,
  output logic [31:0]                    readdata_o,
  output logic                           readdatavalid_o,
  output logic                           waitrequest_o,
  output logic                           hps_mem_stb_o,
  output logic                           hps_mem_write_o,
  output logic [31:0]                    hps_mem_wdata_o,
  output logic [7:0]                     hps_mem_addr_o,
  input  logic [31:0]                    hps_mem_rdata_i,
  input  logic                           hps_mem_rdy_i,
  output logic                           hps_rs_exec_o,
  output logic                           hps_rs_en_decn_o,
  output logic [7:0]                     hps_rs_addr_o
);

  // Handshake: an Avalon transfer is accepted on the rising edge where
  // chipselect_i & (read_i | write_i) is high and waitrequest_o is low; read
  // data follows later as a one-cycle readdatavalid_o pulse.
  state_e     state;
  state_e     state_nxt;
  logic       req;
  logic [2:0] cmd;
  logic       is_mem;
  logic       is_rs;
  logic       timed_out;
  logic       unused_addr;

  assign req         = chipselect_i & (read_i | write_i);
  assign cmd         = address_i[10:8];
  assign is_mem      = (cmd == CMD_MEM);
  assign is_rs       = (cmd == CMD_ENC) || (cmd == CMD_DEC);
  assign unused_addr = ^address_i;

`ifdef HPS_RS_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] wait_cnt;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the last of TIMEOUT_CYCLES consecutive WAIT cycles without a ready.
  assign timed_out = (state == ST_WAIT) && !hps_mem_rdy_i &&
                     (wait_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hps_mem_stb_o = 1'b0;
    // Command and reserved accesses complete in IDLE without a stall.
    waitrequest_o = aresetn_i && req && (state != ST_DONE) &&
                    !((state == ST_IDLE) && !is_mem);
    case (state)
      ST_IDLE: if (req && is_mem) state_nxt = ST_REQ;
      ST_REQ: begin
        hps_mem_stb_o = 1'b1;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: if (hps_mem_rdy_i || timed_out) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      readdata_o       <= '0;
      readdatavalid_o  <= 1'b0;
      hps_mem_write_o  <= 1'b0;
      hps_mem_wdata_o  <= '0;
      hps_mem_addr_o   <= '0;
      hps_rs_exec_o    <= 1'b0;
      hps_rs_en_decn_o <= 1'b0;
      hps_rs_addr_o    <= '0;
    end else begin
      readdatavalid_o <= 1'b0;
      hps_rs_exec_o   <= 1'b0;
      if ((state == ST_IDLE) && req) begin
        if (is_mem) begin
          hps_mem_addr_o  <= address_i[7:0];
          hps_mem_wdata_o <= writedata_i;
          hps_mem_write_o <= write_i;
        end else if (write_i) begin
          if (is_rs) begin
            hps_rs_exec_o    <= 1'b1;
            hps_rs_addr_o    <= address_i[7:0];
            hps_rs_en_decn_o <= (cmd == CMD_ENC);
          end
        end else begin
          // Non-memory reads answer immediately with zero.
          readdata_o      <= '0;
          readdatavalid_o <= 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        if (hps_mem_rdy_i) begin
          readdata_o      <= hps_mem_rdata_i;
          readdatavalid_o <= !hps_mem_write_o;
        end else if (timed_out) begin
          readdata_o      <= TIMEOUT_RDATA;
          readdatavalid_o <= !hps_mem_write_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_hps_rs_control_bridge.sv
// Self-checking bench for hps_rs_control_bridge: Avalon driver tasks, a delayed-ready
// memory responder and expected-result queues for read data, memory strobes and RS commands.
module tb_hps_rs_control_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata_o;
  logic        readdatavalid_o;
  logic        waitrequest_o;
  logic        hps_mem_stb_o;
  logic        hps_mem_write_o;
  logic [31:0] hps_mem_wdata_o;
  logic [7:0]  hps_mem_addr_o;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;
  logic        hps_rs_exec_o;
  logic        hps_rs_en_decn_o;
  logic [7:0]  hps_rs_addr_o;

  // clock / reset
  always #5 clk = ~clk;

  hps_rs_control_bridge #(.SLAVE_ADDR_BITWIDTH(32)) dut (
    .aclk_i           (clk),
    .aresetn_i        (rst_n),
    .chipselect_i     (chipselect),
    .read_i           (read),
    .write_i          (write),
    .address_i        (address),
    .writedata_i      (writedata),
    .readdata_o       (readdata_o),
    .readdatavalid_o  (readdatavalid_o),
    .waitrequest_o    (waitrequest_o),
    .hps_mem_stb_o    (hps_mem_stb_o),
    .hps_mem_write_o  (hps_mem_write_o),
    .hps_mem_wdata_o  (hps_mem_wdata_o),
    .hps_mem_addr_o   (hps_mem_addr_o),
    .hps_mem_rdata_i  (mem_rdata),
    .hps_mem_rdy_i    (mem_rdy),
    .hps_rs_exec_o    (hps_rs_exec_o),
    .hps_rs_en_decn_o (hps_rs_en_decn_o),
    .hps_rs_addr_o    (hps_rs_addr_o)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [40:0] mem_exp_q[$];
  logic [8:0]  rs_exp_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] dev_mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stb_cnt = 0;
  int          stb_exp = 0;
  int          exec_cnt = 0;
  int          exec_exp = 0;
  int          rdy_delay = 3;
  logic        mem_hang = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor
  initial begin
    logic [40:0] e;
    logic [8:0]  r;
    forever begin
      @(negedge clk);
      if (hps_mem_stb_o) begin
        stb_cnt++;
        if (mem_exp_q.size() == 0) check("stb_spurious", 64'(hps_mem_stb_o), 64'd0);
        else begin
          e = mem_exp_q.pop_front();
          check("mem_write", 64'(hps_mem_write_o), 64'(e[40]));
          check("mem_addr", 64'(hps_mem_addr_o), 64'(e[39:32]));
          if (e[40]) check("mem_wdata", 64'(hps_mem_wdata_o), 64'(e[31:0]));
        end
      end
      if (readdatavalid_o) begin
        if (exp_q.size() == 0) check("rdv_spurious", 64'(readdatavalid_o), 64'd0);
        else check("readdata", 64'(readdata_o), 64'(exp_q.pop_front()));
      end
      if (hps_rs_exec_o) begin
        exec_cnt++;
        if (rs_exp_q.size() == 0) check("exec_spurious", 64'(hps_rs_exec_o), 64'd0);
        else begin
          r = rs_exp_q.pop_front();
          check("rs_cmd", 64'({hps_rs_en_decn_o, hps_rs_addr_o}), 64'(r));
        end
      end
    end
  end

  // memory responder: ready rdy_delay cycles after the strobe
  initial begin
    logic [40:0] cap;
    int          left;
    logic        busy;
    busy = 1'b0;
    left = 0;
    cap  = '0;
    forever begin
      @(negedge clk);
      mem_rdy = 1'b0;
      if (!rst_n) busy = 1'b0;
      else if (hps_mem_stb_o) begin
        if (!mem_hang) begin
          busy = 1'b1;
          left = rdy_delay;
          cap  = {hps_mem_write_o, hps_mem_addr_o, hps_mem_wdata_o};
        end
      end else if (busy) begin
        if (left <= 1) begin
          check("mem_hold", 64'({hps_mem_write_o, hps_mem_addr_o, hps_mem_wdata_o}), 64'(cap));
          if (cap[40]) dev_mem[cap[39:32]] = cap[31:0];
          mem_rdata = dev_mem[cap[39:32]];
          mem_rdy   = 1'b1;
          busy      = 1'b0;
        end else left--;
      end
    end
  end

  // driver tasks
  task automatic avm(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] data, output int stall);
    @(negedge clk);
    chipselect = 1'b1;
    write      = wr;
    read       = rd;
    address    = addr;
    writedata  = data;
    #1;
    stall = 0;
    while (waitrequest_o && stall < 1000) begin
      @(negedge clk);
      stall++;
    end
    if (waitrequest_o) check("xfer_timeout", 64'(waitrequest_o), 64'd0);
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic both);
    int stall;
    mem_exp_q.push_back({1'b1, addr[7:0], data});
    model_mem[addr[7:0]] = data;
    stb_exp++;
    avm(1'b1, both, addr, data, stall);
    check("wr_stall", 64'(stall), 64'(rdy_delay + 2));
    check("wr_stb_count", 64'(stb_cnt), 64'(stb_exp));
  endtask

  task automatic mem_read(input logic [31:0] addr);
    int stall;
    mem_exp_q.push_back({1'b0, addr[7:0], 32'h0});
    exp_q.push_back(model_mem[addr[7:0]]);
    stb_exp++;
    avm(1'b0, 1'b1, addr, 32'h0, stall);
    check("rd_stall", 64'(stall), 64'(rdy_delay + 2));
    check("rd_stb_count", 64'(stb_cnt), 64'(stb_exp));
  endtask

  task automatic rs_cmd(input logic enc, input logic [7:0] addr);
    int stall;
    rs_exp_q.push_back({enc, addr});
    exec_exp++;
    avm(1'b1, 1'b0, {21'h0, enc ? 3'b011 : 3'b010, addr}, 32'h0, stall);
    check("rs_stall", 64'(stall), 64'd0);
    @(negedge clk);
    check("rs_exec_count", 64'(exec_cnt), 64'(exec_exp));
    check("rs_hold", 64'({hps_rs_en_decn_o, hps_rs_addr_o}), 64'({enc, addr}));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readdata"}, 64'(readdata_o), 64'd0);
    check({tag, "_outs"}, 64'({readdatavalid_o, waitrequest_o, hps_mem_stb_o, hps_mem_write_o,
                               hps_rs_exec_o, hps_rs_en_decn_o}), 64'd0);
    check({tag, "_buses"}, 64'({hps_mem_wdata_o, hps_mem_addr_o, hps_rs_addr_o}), 64'd0);
  endtask

  // stimulus
  initial begin
    int stall;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      dev_mem[i]   = '0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    mem_write(32'h004, 32'h89ABCDEF, 1'b0);
    mem_read(32'h004);
    rs_cmd(1'b1, 8'h08);
    rs_cmd(1'b0, 8'h0C);
    mem_write(32'h000, 32'h13572468, 1'b1);
    check("both_rdv_pending", 64'(exp_q.size()), 64'd0);

    // reserved command: write dropped, read returns zero
    avm(1'b1, 1'b0, 32'h510, 32'hFFFFFFFF, stall);
    check("resv_wr_stall", 64'(stall), 64'd0);
    @(negedge clk);
    check("resv_wr_stb", 64'(stb_cnt), 64'(stb_exp));
    check("resv_wr_exec", 64'(exec_cnt), 64'(exec_exp));
    exp_q.push_back(32'h0);
    avm(1'b0, 1'b1, 32'h120, 32'h0, stall);
    check("resv_rd_stall", 64'(stall), 64'd0);
    @(negedge clk);
    check("resv_rd_done", 64'(exp_q.size()), 64'd0);

    // address bits above [10:0] are ignored
    mem_read(32'hFFFFF804);

    for (int i = 0; i < 8; i++) begin
      rdy_delay = $urandom_range(1, 6);
      a = 8'($urandom_range(0, 255));
      mem_write({24'h0, a}, $urandom, 1'b0);
      rdy_delay = $urandom_range(1, 6);
      mem_read({24'h0, a});
    end
    rdy_delay = 3;

    // reset while the bridge waits for memory
    mem_hang = 1'b1;
    mem_exp_q.push_back({1'b0, 8'h10, 32'h0});
    stb_exp++;
    @(negedge clk);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 32'h010;
    repeat (4) @(negedge clk);
    check("pre_reset_wait", 64'(waitrequest_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    rst_n      = 1'b1;
    mem_hang   = 1'b0;
    check("reset_stb_count", 64'(stb_cnt), 64'(stb_exp));
    mem_read(32'h004);

`ifdef HPS_RS_BRIDGE_TIMEOUT_EN
    mem_hang = 1'b1;
    mem_exp_q.push_back({1'b0, 8'h20, 32'h0});
    exp_q.push_back(32'hDEADBEEF);
    stb_exp++;
    avm(1'b0, 1'b1, 32'h020, 32'h0, stall);
    check("timeout_stall", 64'(stall), 64'd258);
    mem_hang = 1'b0;
`endif

    repeat (4) @(negedge clk);
    check("final_rdv_q", 64'(exp_q.size()), 64'd0);
    check("final_mem_q", 64'(mem_exp_q.size()), 64'd0);
    check("final_rs_q", 64'(rs_exp_q.size()), 64'd0);
    check("final_stb_count", 64'(stb_cnt), 64'(stb_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
